// File: rtl/fib_arbiter.sv
// fib_arbiter
//
// Shares one fib engine among NUM_REQ requesters. Each requester posts an
// n value with a one-cycle strobe. The block holds at most one pending request
// per requester and grants pending requesters in round-robin order. For each
// granted request it strobes the engine, waits for the engine's busy pulse to
// end, and then reports the result tagged with the requester id.
//
// Ports:
//   i_clk         clock
//   i_reset       synchronous active-high reset
//   i_req_stb     per-requester request strobe (1-cycle pulse)
//   i_req_n       per-requester n, slice k = [k*WIDTH +: WIDTH]
//   o_req_busy    requester k has a request pending or in service
//   o_fib_stb     strobe to the engine (one cycle per job)
//   o_fib_n       n presented to the engine (holds its last value)
//   i_fib_busy    engine busy
//   i_fib_result  engine result, valid on the first cycle busy is low
//   o_done_valid  1-cycle result pulse
//   o_done_id     requester id of the result (held until the next result)
//   o_done_fib    result value (held until the next result)

module fib_arbiter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req_stb,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_n,
  output logic [NUM_REQ-1:0]       o_req_busy,
  output logic                     o_fib_stb,
  output logic [WIDTH-1:0]         o_fib_n,
  input  logic                     i_fib_busy,
  input  logic [WIDTH-1:0]         i_fib_result,
  output logic                     o_done_valid,
  output logic [ID_W-1:0]          o_done_id,
  output logic [WIDTH-1:0]         o_done_fib
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_REPORT
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [WIDTH-1:0]   n_q [NUM_REQ];
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fib_stb_q;
  logic [WIDTH-1:0]   fib_n_q;
  logic               done_valid_q;
  logic [ID_W-1:0]    done_id_q;
  logic [WIDTH-1:0]   done_fib_q;

  // Round-robin pick: first pending index after last_grant, wrapping at
  // NUM_REQ. Offset NUM_REQ lands back on last_grant itself, so a lone
  // requester can still be re-granted.
  logic [ID_W-1:0] grant_d;
  logic [ID_W-1:0] rr_idx;
  logic            rr_found;

  always_comb begin
    grant_d  = last_grant_q;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_idx = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (!rr_found && pending_q[rr_idx]) begin
        grant_d  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        n_q[k] <= '0;
      end
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      fib_stb_q    <= 1'b0;
      fib_n_q      <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_fib_q   <= '0;
    end else begin
      // Capture new requests only for requesters without one outstanding;
      // a repeat strobe leaves the latched n untouched.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (i_req_stb[k] && !pending_q[k]) begin
          pending_q[k] <= 1'b1;
          n_q[k]       <= i_req_n[k*WIDTH +: WIDTH];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            grant_q   <= grant_d;
            fib_n_q   <= n_q[grant_d];
            fib_stb_q <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          fib_stb_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT_START;
        end

        S_WAIT_START: begin
          if (i_fib_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            // Engine never raised busy: treat as a zero-latency job.
            done_fib_q   <= i_fib_result;
            done_id_q    <= grant_q;
            done_valid_q <= 1'b1;
            state_q      <= S_REPORT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_DONE: begin
          if (!i_fib_busy) begin
            done_fib_q   <= i_fib_result;
            done_id_q    <= grant_q;
            done_valid_q <= 1'b1;
            state_q      <= S_REPORT;
          end
        end

        S_REPORT: begin
          // Placed after the capture loop so the clear wins; a strobe from
          // the granted requester this cycle is already blocked by pending.
          done_valid_q       <= 1'b0;
          pending_q[grant_q] <= 1'b0;
          last_grant_q       <= grant_q;
          state_q            <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_busy   = pending_q;
  assign o_fib_stb    = fib_stb_q;
  assign o_fib_n      = fib_n_q;
  assign o_done_valid = done_valid_q;
  assign o_done_id    = done_id_q;
  assign o_done_fib   = done_fib_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter
//
// Directed bench for fib_arbiter with a behavioural fib engine: busy rises
// the cycle after the strobe, stays high n cycles, and the result fib(n)
// appears as busy falls. A zero-busy mode never raises busy and drives 0x2A.

module tb_fib_arbiter;

  localparam int WIDTH         = 8;
  localparam int NUM_REQ       = 4;
  localparam int ID_W          = 2;
  localparam int START_TIMEOUT = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_stb;
  logic [NUM_REQ*WIDTH-1:0] req_n;
  logic [NUM_REQ-1:0]       req_busy;
  logic                     fib_stb;
  logic [WIDTH-1:0]         fib_n;
  logic                     eng_busy;
  logic [WIDTH-1:0]         eng_res;
  logic                     done_valid;
  logic [ID_W-1:0]          done_id;
  logic [WIDTH-1:0]         done_fib;

  always #5 clk = ~clk;

  fib_arbiter #(
    .WIDTH        (WIDTH),
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_stb   (req_stb),
    .i_req_n     (req_n),
    .o_req_busy  (req_busy),
    .o_fib_stb   (fib_stb),
    .o_fib_n     (fib_n),
    .i_fib_busy  (eng_busy),
    .i_fib_result(eng_res),
    .o_done_valid(done_valid),
    .o_done_id   (done_id),
    .o_done_fib  (done_fib)
  );

  // ---------------- behavioural engine ----------------
  logic       eng_zero = 1'b0;
  logic [7:0] eng_cnt;
  logic [7:0] eng_n;

  function automatic logic [7:0] fib_f(input logic [7:0] n);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    a = 8'd0;
    b = 8'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 8'd0;
      eng_res  <= 8'd0;
      eng_n    <= 8'd0;
    end else if (eng_zero) begin
      eng_busy <= 1'b0;
      eng_res  <= 8'h2A;
    end else if (eng_busy) begin
      if (eng_cnt == 8'd1) begin
        eng_busy <= 1'b0;
        eng_res  <= fib_f(eng_n);
      end
      eng_cnt <= eng_cnt - 8'd1;
    end else if (fib_stb) begin
      eng_n <= fib_n;
      if (fib_n == 8'd0) begin
        eng_res <= 8'd0;
      end else begin
        eng_busy <= 1'b1;
        eng_cnt  <= fib_n;
      end
    end
  end

  // ---------------- monitor ----------------
  int         cyc      = 0;
  int         stb_cnt  = 0;
  int         stb_cyc  = 0;
  int         done_cyc = 0;
  logic [7:0] stb_n    = 8'd0;
  int         done_ids[$];
  int         done_fibs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fib_stb) begin
      stb_cnt <= stb_cnt + 1;
      stb_n   <= fib_n;
      stb_cyc <= cyc;
    end
    if (done_valid) begin
      done_ids.push_back(int'(done_id));
      done_fibs.push_back(int'(done_fib));
      done_cyc <= cyc;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // All stimulus and sampling happens just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic post(input int k, input logic [7:0] n);
    req_stb[k]             = 1'b1;
    req_n[k*WIDTH +: WIDTH] = n;
    step();
    req_stb[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (done_ids.size() < target && i < budget) begin
      step();
      i++;
    end
    if (done_ids.size() < target) chk({tag, "_timeout"}, done_ids.size(), target);
  endtask

  task automatic wait_stb(input int base, input int budget, input string tag);
    int i;
    i = 0;
    while (stb_cnt == base && i < budget) begin
      step();
      i++;
    end
    chk({tag, "_stb_seen"}, stb_cnt - base, 1);
  endtask

  int bd;
  int bs;

  initial begin
    rst     = 1'b1;
    req_stb = '0;
    req_n   = '0;

    // ---- reset state ----
    do_reset();
    chk("rst_fib_stb",    fib_stb,    0);
    chk("rst_fib_n",      fib_n,      0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_id",    done_id,    0);
    chk("rst_done_fib",   done_fib,   0);
    chk("rst_req_busy",   req_busy,   0);

    // ---- 1: single request, n=10 -> 55, ISSUE to REPORT = B+2 cycles ----
    bd = done_ids.size();
    bs = stb_cnt;
    post(0, 8'd10);
    chk("t1_busy_set", req_busy[0], 1);
    wait_dones(bd + 1, 60, "t1");
    chk("t1_id",       done_ids[bd],  0);
    chk("t1_fib",      done_fibs[bd], 55);
    chk("t1_stb_cnt",  stb_cnt - bs,  1);
    chk("t1_stb_n",    stb_n,         10);
    chk("t1_latency",  done_cyc - stb_cyc, 12);
    chk("t1_busy_rep", req_busy[0],   1);
    step();
    chk("t1_busy_clr", req_busy[0],   0);
    chk("t1_pulse",    done_valid,    0);
    chk("t1_hold_fib", done_fib,      55);

    // ---- 2: four simultaneous requests from a fresh reset ----
    do_reset();
    bd = done_ids.size();
    req_stb = 4'b1111;
    req_n   = {8'd13, 8'd3, 8'd2, 8'd1};
    step();
    req_stb = '0;
    chk("t2_busy_all", req_busy, 4'b1111);
    wait_dones(bd + 4, 200, "t2");
    repeat (20) step();
    chk("t2_count", done_ids.size() - bd, 4);
    if (done_ids.size() >= bd + 4) begin
      chk("t2_id0",  done_ids[bd],      0);
      chk("t2_fib0", done_fibs[bd],     1);
      chk("t2_id1",  done_ids[bd+1],    1);
      chk("t2_fib1", done_fibs[bd+1],   1);
      chk("t2_id2",  done_ids[bd+2],    2);
      chk("t2_fib2", done_fibs[bd+2],   2);
      chk("t2_id3",  done_ids[bd+3],    3);
      chk("t2_fib3", done_fibs[bd+3],   233);
    end

    // ---- 3: fairness, req 1 strobes every cycle, req 3 posts once ----
    bd = done_ids.size();
    bs = stb_cnt;
    req_n[1*WIDTH +: WIDTH] = 8'd2;
    req_stb[1] = 1'b1;
    wait_stb(bs, 20, "t3");
    post(3, 8'd4);
    wait_dones(bd + 3, 200, "t3");
    req_stb[1] = 1'b0;
    repeat (30) step();
    chk("t3_count", done_ids.size() - bd, 3);
    chk("t3_idle",  req_busy, 0);
    if (done_ids.size() >= bd + 3) begin
      chk("t3_id0",  done_ids[bd],    1);
      chk("t3_fib0", done_fibs[bd],   1);
      chk("t3_id1",  done_ids[bd+1],  3);
      chk("t3_fib1", done_fibs[bd+1], 3);
      chk("t3_id2",  done_ids[bd+2],  1);
    end

    // ---- 4: duplicate strobe while pending is ignored ----
    bd = done_ids.size();
    bs = stb_cnt;
    post(2, 8'd5);
    post(2, 8'd7);
    wait_dones(bd + 1, 60, "t4");
    repeat (30) step();
    chk("t4_count",   done_ids.size() - bd, 1);
    chk("t4_stb_cnt", stb_cnt - bs, 1);
    chk("t4_stb_n",   stb_n, 5);
    if (done_ids.size() >= bd + 1) begin
      chk("t4_id",  done_ids[bd],  2);
      chk("t4_fib", done_fibs[bd], 5);
    end

    // ---- 5: engine never raises busy ----
    eng_zero = 1'b1;
    step();
    bd = done_ids.size();
    post(0, 8'd9);
    wait_dones(bd + 1, 60, "t5");
    chk("t5_latency", done_cyc - stb_cyc, START_TIMEOUT + 1);
    if (done_ids.size() >= bd + 1) begin
      chk("t5_id",  done_ids[bd],  0);
      chk("t5_fib", done_fibs[bd], 8'h2A);
    end
    step();
    eng_zero = 1'b0;
    repeat (3) step();

    // ---- 6: reset while waiting on the engine ----
    bs = stb_cnt;
    bd = done_ids.size();
    post(3, 8'd12);
    wait_stb(bs, 20, "t6");
    post(0, 8'd3);
    repeat (2) step();
    chk("t6_pre_busy", req_busy, 4'b1001);
    rst = 1'b1;
    step();
    chk("t6_fib_stb",    fib_stb,    0);
    chk("t6_fib_n",      fib_n,      0);
    chk("t6_done_valid", done_valid, 0);
    chk("t6_done_id",    done_id,    0);
    chk("t6_done_fib",   done_fib,   0);
    chk("t6_req_busy",   req_busy,   0);
    rst = 1'b0;
    step();
    chk("t6_no_done", done_ids.size() - bd, 0);
    bd = done_ids.size();
    post(1, 8'd6);
    wait_dones(bd + 1, 60, "t6");
    if (done_ids.size() >= bd + 1) begin
      chk("t6_id",  done_ids[bd],  1);
      chk("t6_fib", done_fibs[bd], 8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
